// File: rtl/bcd_scan_display.sv
// Multiplexed BCD-to-7-segment scanner with a shadow register and registered led/an/frame_done outputs.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros; digit 0 is never blanked.
module bcd_scan_display #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned PRESCALE   = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd,
   output logic [7:1]              led,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [BCD_W-1:0]      shadow;
   logic [PSC_W-1:0]      psc, psc_next;
   logic [IDX_W-1:0]      idx, idx_next;
   logic                  slot_end, frame_end;
   logic [3:0]            cur_digit, dig;
   logic                  cur_blank;
   logic [NUM_DIGITS-1:0] an_next;
   logic [6:0]            seg_next;
`ifdef LEADING_ZERO_BLANK_EN
   logic                  zero_above;
`endif

   // Segment pattern {a,b,c,d,e,f,g}; values 10-15 show a dash.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   // Prescaler and digit index advance.
   always_comb begin
      slot_end  = (psc == PSC_LAST);
      frame_end = slot_end && (idx == IDX_LAST);
      psc_next  = slot_end ? '0 : psc + PSC_W'(1);
      idx_next  = idx;
      if (slot_end) begin
         idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
   end

   // Select the current digit and anode; walk from the top digit down to track leading zeros.
   always_comb begin
      cur_digit = '0;
      cur_blank = 1'b0;
      an_next   = '1;
      dig       = '0;
`ifdef LEADING_ZERO_BLANK_EN
      zero_above = 1'b1;
`endif
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         dig = shadow[4*i +: 4];
         if (idx == IDX_W'(i)) begin
            cur_digit  = dig;
            an_next[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            cur_blank  = zero_above && (dig == 4'd0) && (i != 0);
`endif
         end
`ifdef LEADING_ZERO_BLANK_EN
         zero_above = zero_above && (dig == 4'd0);
`endif
      end
      seg_next = cur_blank ? 7'b0000000 : seg7(cur_digit);
   end

   // Shadow capture: all digits update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= bcd;
      end
   end

   // Scan state and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc        <= '0;
         idx        <= '0;
         led        <= '0;
         an         <= '1;
         frame_done <= 1'b0;
      end else if (!en) begin
         psc        <= '0;
         idx        <= '0;
         led        <= '0;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         psc        <= psc_next;
         idx        <= idx_next;
         led        <= seg_next;
         an         <= an_next;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a 4-digit/PRESCALE=3 instance and a 1-digit/PRESCALE=1 instance.
module tb_bcd_scan_display;

   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0110011;
   localparam logic [6:0] S7 = 7'b1110000;
   localparam logic [6:0] S9 = 7'b1111011;
   localparam logic [6:0] SD = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b0000000;
`else
   localparam logic [6:0] LZ = S0;
`endif

   logic        clk;
   logic        rst_n, en, load;
   logic [15:0] bcd;
   logic [7:1]  led;
   logic [3:0]  an;
   logic        frame_done;

   logic        en1, load1;
   logic [3:0]  bcd1;
   logic [7:1]  led1;
   logic [0:0]  an1;
   logic        frame_done1;

   int n_assert = 0;
   int n_fail   = 0;
   logic [6:0] exp_led [4];

   bcd_scan_display #(.NUM_DIGITS(4), .PRESCALE(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd),
      .led(led), .an(an), .frame_done(frame_done)
   );

   bcd_scan_display #(.NUM_DIGITS(1), .PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .bcd(bcd1),
      .led(led1), .an(an1), .frame_done(frame_done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] ean, input logic [6:0] eled, input logic efd);
      chk({tag, "_an"}, 8'(an), 8'(ean));
      chk({tag, "_led"}, 8'(led), 8'(eled));
      chk({tag, "_fd"}, 8'(frame_done), 8'(efd));
   endtask

   // Expected anode pattern for digit d in the 4-digit instance.
   function automatic logic [3:0] an_of(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   initial begin
      rst_n = 1'b1; en = 1'b0; load = 1'b0; bcd = 16'h0000;
      en1 = 1'b1; load1 = 1'b1; bcd1 = 4'h9;
      #2 rst_n = 1'b0;
      #1;
      chk_out("reset", 4'b1111, 7'b0, 1'b0);

      // Load 1234 while disabled, then scan two and a half frames.
      tick();
      rst_n = 1'b1; load = 1'b1; bcd = 16'h1234;
      tick();
      load = 1'b0;
      chk_out("disabled", 4'b1111, 7'b0, 1'b0);
      exp_led[0] = S4; exp_led[1] = S3; exp_led[2] = S2; exp_led[3] = S1;
      en = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk_out($sformatf("scan1234_k%0d", k), an_of(((k - 1) / 3) % 4),
                 exp_led[((k - 1) / 3) % 4], (k % 12) == 0);
         chk($sformatf("n1_an_k%0d", k), 8'(an1), 8'h00);
         chk($sformatf("n1_led_k%0d", k), 8'(led1), 8'(S9));
         chk($sformatf("n1_fd_k%0d", k), 8'(frame_done1), 8'h01);
      end

      // Drop enable during digit 2, then restart with a fresh slot at digit 0.
      en = 1'b0;
      tick();
      chk_out("en_low1", 4'b1111, 7'b0, 1'b0);
      tick();
      chk_out("en_low2", 4'b1111, 7'b0, 1'b0);
      en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_out($sformatf("restart_k%0d", k), an_of((k - 1) / 3), exp_led[(k - 1) / 3], 1'b0);
      end

      // 00A7: dash on digit 1, leading zeros on digits 3 and 2.
      en = 1'b0; load = 1'b1; bcd = 16'h00A7;
      tick();
      load = 1'b0; en = 1'b1;
      exp_led[0] = S7; exp_led[1] = SD; exp_led[2] = LZ; exp_led[3] = LZ;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk_out($sformatf("a7_k%0d", k), an_of((k - 1) / 3), exp_led[(k - 1) / 3], k == 12);
      end

      // Load 0000 on the edge where digit 0's slot ends; digit 1 shows it one cycle later.
      for (int k = 1; k <= 13; k++) begin
         if (k == 3) begin
            load = 1'b1; bcd = 16'h0000;
         end
         tick();
         load = 1'b0;
         if (k <= 3)
            chk_out($sformatf("z_k%0d", k), 4'b1110, S7, 1'b0);
         else if (k <= 12)
            chk_out($sformatf("z_k%0d", k), an_of((k - 1) / 3), LZ, k == 12);
         else
            chk_out($sformatf("z_k%0d", k), 4'b1110, S0, 1'b0);
      end

      // Reset mid-slot on digit 1 with 1234 loaded.
      load = 1'b1; bcd = 16'h1234;
      tick();
      load = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk_out("async_rst", 4'b1111, 7'b0, 1'b0);
      chk("async_rst_n1_an", 8'(an1), 8'h01);
      chk("async_rst_n1_led", 8'(led1), 8'h00);
      chk("async_rst_n1_fd", 8'(frame_done1), 8'h00);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk_out($sformatf("post_rst_k%0d", k), an_of((k - 1) / 3), (k <= 3) ? S0 : LZ, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
